// File: rtl/periph_dispatch_pkg.sv
// Shared constants for the peripheral write dispatcher.
// Channel indices map processor store strobes to peripherals.
package periph_pkg;
    localparam int CH_PPU     = 0;
    localparam int CH_ACC     = 1;
    localparam int CH_COMM    = 2;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_NUM_CH = 3;
    localparam int DEF_DEPTH  = 4;
endpackage

// File: rtl/periph_dispatch_if.sv
// Processor-to-peripheral dispatch bus: write strobes in,
// per-channel valid/ready streams and status out.
interface periph_dispatch_if #(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [NUM_CH-1:0]             wr_en;
    logic [DATA_W-1:0]             wr_data;
    logic [NUM_CH-1:0]             out_valid;
    logic [NUM_CH-1:0][DATA_W-1:0] out_data;
    logic [NUM_CH-1:0]             out_ready;
    logic [NUM_CH-1:0]             full;
    logic [NUM_CH-1:0][LVL_W-1:0]  level;
    logic [NUM_CH-1:0]             overflow;
    logic [NUM_CH-1:0]             ovf_clr;

    modport master (
        output wr_en, wr_data, out_ready, ovf_clr,
        input  out_valid, out_data, full, level, overflow
    );

    modport slave (
        input  wr_en, wr_data, out_ready, ovf_clr,
        output out_valid, out_data, full, level, overflow
    );
endinterface

// File: rtl/periph_dispatch_chan_fifo.sv
// One dispatch channel: circular FIFO with level, full and
// sticky overflow; head word is zero whenever the FIFO is empty.
module chan_fifo #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 4,
    localparam int LVL_W  = $clog2(DEPTH + 1),
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop_ready,
    output logic              valid,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic [LVL_W-1:0]  level,
    output logic              ovf,
    input  logic              ovf_clr
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [LVL_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              pop, wr_ok;

    assign valid = (cnt_q != '0);
    assign full  = (cnt_q == LVL_W'(DEPTH));
    assign level = cnt_q;
    assign ovf   = ovf_q;
    assign dout  = valid ? mem_q[rptr_q] : '0;

    // A pop frees the head slot in the same cycle, so a full FIFO still accepts.
    assign pop   = valid & pop_ready;
    assign wr_ok = push & (~full | pop);

    always_comb begin
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        cnt_d  = cnt_q;
        if (pop)   rptr_d = rptr_q + PTR_W'(1);
        if (wr_ok) wptr_d = wptr_q + PTR_W'(1);
        if (wr_ok & ~pop) cnt_d = cnt_q + LVL_W'(1);
        if (pop & ~wr_ok) cnt_d = cnt_q - LVL_W'(1);
        ovf_d = (push & ~wr_ok) | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_ok) mem_q[wptr_q] <= din;
    end
endmodule

// File: rtl/periph_dispatch.sv
// Write dispatcher: fans processor store strobes out to one
// buffered channel per peripheral and packs channel status.
module periph_dispatch
    import periph_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int NUM_CH = DEF_NUM_CH,
    parameter  int DEPTH  = DEF_DEPTH,
    localparam int LVL_W  = $clog2(DEPTH + 1)
) (
    input logic          sys_clk,
    input logic          rst_n,
    periph_dispatch_if.slave bus
);
    logic [NUM_CH-1:0]             valid_w;
    logic [NUM_CH-1:0][DATA_W-1:0] data_w;
    logic [NUM_CH-1:0]             full_w;
    logic [NUM_CH-1:0][LVL_W-1:0]  level_w;
    logic [NUM_CH-1:0]             ovf_w;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        chan_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .sys_clk   (sys_clk),
            .rst_n     (rst_n),
            .push      (bus.wr_en[c]),
            .din       (bus.wr_data),
            .pop_ready (bus.out_ready[c]),
            .valid     (valid_w[c]),
            .dout      (data_w[c]),
            .full      (full_w[c]),
            .level     (level_w[c]),
            .ovf       (ovf_w[c]),
            .ovf_clr   (bus.ovf_clr[c])
        );
    end

    assign bus.out_valid = valid_w;
    assign bus.out_data  = data_w;
    assign bus.full      = full_w;
    assign bus.level     = level_w;
    assign bus.overflow  = ovf_w;
endmodule

// File: tb/tb_periph_dispatch.sv
// Directed bench for periph_dispatch: reset, pass-through,
// backpressure, overflow, full push+pop, broadcast and reset.
module tb_periph_dispatch;
    import periph_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    periph_dispatch_if bus ();

    periph_dispatch dut (
        .sys_clk (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.wr_en     = 3'b111;
        bus.wr_data   = 32'h1234_5678;
        bus.out_ready = 3'b000;
        bus.ovf_clr   = 3'b000;
        repeat (3) tick();
        chk("rst_valid", 64'(bus.out_valid), 64'h0);
        chk("rst_data", 64'(bus.out_data[CH_PPU]), 64'h0);
        chk("rst_level", 64'(bus.level), 64'h0);
        chk("rst_full", 64'(bus.full), 64'h0);
        chk("rst_ovf", 64'(bus.overflow), 64'h0);

        bus.wr_en = 3'b000;
        rst_n     = 1'b1;
        repeat (10) tick();
        chk("idle_valid", 64'(bus.out_valid), 64'h0);
        chk("idle_level", 64'(bus.level), 64'h0);

        // pass-through
        bus.out_ready = 3'b111;
        bus.wr_en     = 3'b001;
        bus.wr_data   = 32'hDEAD_BEEF;
        tick();
        bus.wr_en = 3'b000;
        chk("pt_valid", 64'(bus.out_valid), 64'h1);
        chk("pt_data", 64'(bus.out_data[CH_PPU]), 64'hDEAD_BEEF);
        chk("pt_lvl1", 64'(bus.level[CH_PPU]), 64'd1);
        tick();
        chk("pt_valid0", 64'(bus.out_valid), 64'h0);
        chk("pt_lvl0", 64'(bus.level[CH_PPU]), 64'd0);
        chk("pt_data0", 64'(bus.out_data[CH_PPU]), 64'h0);

        // backpressure and ordering on ch1
        bus.out_ready = 3'b101;
        for (int i = 1; i <= 4; i++) begin
            bus.wr_en   = 3'b010;
            bus.wr_data = 32'(i);
            tick();
        end
        bus.wr_en = 3'b000;
        chk("bp_full", 64'(bus.full[CH_ACC]), 64'h1);
        chk("bp_level", 64'(bus.level[CH_ACC]), 64'd4);
        chk("bp_head", 64'(bus.out_data[CH_ACC]), 64'h1);
        tick();
        chk("bp_stable", 64'(bus.out_data[CH_ACC]), 64'h1);
        bus.out_ready = 3'b111;
        for (int i = 1; i <= 4; i++) begin
            chk("bp_ovalid", 64'(bus.out_valid[CH_ACC]), 64'h1);
            chk("bp_order", 64'(bus.out_data[CH_ACC]), 64'(i));
            tick();
        end
        chk("bp_empty", 64'(bus.out_valid[CH_ACC]), 64'h0);

        // overflow on ch2
        bus.out_ready = 3'b011;
        for (int i = 0; i < 4; i++) begin
            bus.wr_en   = 3'b100;
            bus.wr_data = 32'h10 + 32'(i);
            tick();
        end
        chk("ov_full", 64'(bus.full[CH_COMM]), 64'h1);
        chk("ov_pre", 64'(bus.overflow[CH_COMM]), 64'h0);
        bus.wr_data = 32'h55;
        tick();
        chk("ov_set", 64'(bus.overflow[CH_COMM]), 64'h1);
        chk("ov_level", 64'(bus.level[CH_COMM]), 64'd4);
        bus.wr_data = 32'h66;
        bus.ovf_clr = 3'b100;
        tick();
        chk("ov_setwins", 64'(bus.overflow[CH_COMM]), 64'h1);
        bus.wr_en = 3'b000;
        tick();
        bus.ovf_clr = 3'b000;
        chk("ov_clr", 64'(bus.overflow[CH_COMM]), 64'h0);
        chk("ov_lvl2", 64'(bus.level[CH_COMM]), 64'd4);
        bus.out_ready = 3'b111;
        for (int i = 0; i < 4; i++) begin
            chk("ov_order", 64'(bus.out_data[CH_COMM]), 64'h10 + 64'(i));
            tick();
        end
        chk("ov_drained", 64'(bus.out_valid[CH_COMM]), 64'h0);

        // full channel with simultaneous push and pop
        bus.out_ready = 3'b110;
        for (int i = 0; i < 4; i++) begin
            bus.wr_en   = 3'b001;
            bus.wr_data = 32'h20 + 32'(i);
            tick();
        end
        chk("pp_full", 64'(bus.full[CH_PPU]), 64'h1);
        bus.out_ready = 3'b111;
        bus.wr_data   = 32'h99;
        tick();
        bus.wr_en = 3'b000;
        chk("pp_noovf", 64'(bus.overflow[CH_PPU]), 64'h0);
        chk("pp_level", 64'(bus.level[CH_PPU]), 64'd4);
        chk("pp_h0", 64'(bus.out_data[CH_PPU]), 64'h21);
        tick();
        chk("pp_h1", 64'(bus.out_data[CH_PPU]), 64'h22);
        tick();
        chk("pp_h2", 64'(bus.out_data[CH_PPU]), 64'h23);
        tick();
        chk("pp_h3", 64'(bus.out_data[CH_PPU]), 64'h99);
        tick();
        chk("pp_empty", 64'(bus.out_valid[CH_PPU]), 64'h0);

        // broadcast
        bus.out_ready = 3'b000;
        bus.wr_en     = 3'b101;
        bus.wr_data   = 32'hA5;
        tick();
        bus.wr_en = 3'b000;
        chk("bc_valid", 64'(bus.out_valid), 64'h5);
        chk("bc_d0", 64'(bus.out_data[CH_PPU]), 64'hA5);
        chk("bc_d2", 64'(bus.out_data[CH_COMM]), 64'hA5);
        chk("bc_l1", 64'(bus.level[CH_ACC]), 64'd0);
        chk("bc_d1", 64'(bus.out_data[CH_ACC]), 64'h0);

        // mid-operation reset with three words in ch0
        bus.wr_en   = 3'b001;
        bus.wr_data = 32'hB0;
        tick();
        bus.wr_data = 32'hB1;
        tick();
        bus.wr_en = 3'b000;
        chk("mr_l0", 64'(bus.level[CH_PPU]), 64'd3);
        bus.out_ready = 3'b111;
        rst_n         = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mr_level", 64'(bus.level), 64'h0);
        chk("mr_valid", 64'(bus.out_valid), 64'h0);
        repeat (2) tick();
        chk("mr_valid2", 64'(bus.out_valid), 64'h0);
        chk("mr_data", 64'(bus.out_data), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/periph_dispatch.md
# periph_dispatch

Parametrised write-dispatch block between the processor's interface port and its memory-mapped peripherals (PPU, accelerator, comm link). Each processor store strobe selects one or more channels. The 32-bit `interface_data` word is pushed into that channel's FIFO and presented to the peripheral over a valid/ready handshake. It replaces the per-peripheral hold registers and the fixed one-cycle send delay, adding buffering, backpressure, per-channel fill level and sticky overflow reporting.

## Interface
- `DATA_W`, 32: width of each dispatched word.
- `NUM_CH`, 3: number of peripheral channels (0 = PPU, 1 = accelerator, 2 = comm).
- `DEPTH`, 4: FIFO entries per channel; power of two, ≥ 2.
- `LVL_W`, `$clog2(DEPTH+1)`: level counter width (derived, not overridden).

Ports:
- `sys_clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `wr_en` in `NUM_CH`: per-channel write strobes from the processor (`ppu_send`, `uad`, `snd`, …).
- `wr_data` in `DATA_W`: `interface_data` from the processor.
- `out_valid` out `NUM_CH`: channel head word available.
- `out_data` out `[NUM_CH-1:0][DATA_W-1:0]`: channel head word; 0 when `out_valid`=0.
- `out_ready` in `NUM_CH`: peripheral accepts the head word. Tie to 1 for peripherals without backpressure.
- `full` out `NUM_CH`: channel holds `DEPTH` words.
- `level` out `[NUM_CH-1:0][LVL_W-1:0]`: words held per channel.
- `overflow` out `NUM_CH`: sticky flag; a write was dropped on this channel.
- `ovf_clr` in `NUM_CH`: clears the matching `overflow` bit.

## Operation
- Each channel is an independent circular FIFO with read pointer, write pointer and count.
- **Push:** `wr_en[c]`=1 and (`count`<`DEPTH` or a pop occurs on `c` in the same cycle). The word is written at the write pointer; the pointer increments mod `DEPTH`.
- **Pop:** `out_valid[c] & out_ready[c]`. The read pointer increments mod `DEPTH`.
- **Count:**
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop, including the full and depth-1 cases.
- **Multiple `wr_en` bits set:** the same word is broadcast to every selected channel. Each channel applies its own full/overflow rule.
- **Write to a full channel without a same-cycle pop:** the word is dropped and `overflow[c]` is set. Channel contents are unchanged.
- **`overflow` clear:** `ovf_clr[c]` clears the bit. If set and clear occur in the same cycle, set wins.
- **`out_ready` asserted while `out_valid`=0:** ignored.
- **`wr_en`=0 on all channels:** no state change other than pops.
- **Ordering:** words leave each channel in write order. There is no cross-channel ordering guarantee.

## Timing
- **Reset (`rst_n`=0 at a `sys_clk` edge):**
  - Pointers, counts, `out_valid`, `full`, `level` and `overflow` are all 0.
  - `out_data` is 0.
  - FIFO storage is not cleared.
  - Reset mid-transfer discards all buffered words; no partial handshake survives.
- **Latency:**
  - A word pushed into an empty channel at edge N appears on `out_valid`/`out_data` after edge N, i.e. one cycle. This matches the former `ppu_send_ff` timing.
  - There is no same-cycle bypass.
- **Flag timing:** `full`, `level` and `overflow` are registered state and update at the edge that performs the push or pop.
- **Throughput:** one push and one pop per channel per cycle. With `out_ready` held at 1, back-to-back writes produce back-to-back one-cycle `out_valid` pulses, each one cycle after its write.
- **Handshake rule:** `out_data[c]` is stable while `out_valid[c]`=1 and `out_ready[c]`=0.
- **Pointer wrap:** pointers are `$clog2(DEPTH)` bits and wrap naturally; `count` alone determines full and empty.

## Structure
- Shared package `periph_pkg`:
  - channel index constants `CH_PPU`=0, `CH_ACC`=1, `CH_COMM`=2;
  - default `DATA_W` = 32.
- Sub-module `chan_fifo`, parameters `DATA_W` and `DEPTH`:
  - ports: `push`, `din`, `pop_ready`, `valid`, `dout`, `full`, `level`, `ovf`, `ovf_clr`;
  - instantiated `NUM_CH` times in a generate loop.
- The top level contains only strobe fan-out and output packing.

## Test plan
1. **Reset and idle:** hold `rst_n`=0 with `wr_en`=3'b111 → all outputs 0. Release reset with no writes for 10 cycles → outputs still 0.
2. **Pass-through:** `out_ready`=1, write 0xDEAD_BEEF to ch0 at cycle N → `out_valid[0]`=1 with `out_data[0]`=0xDEAD_BEEF in cycle N+1 only; `level[0]`=1 then 0.
3. **Backpressure and order:** `out_ready[1]`=0, write 0x1, 0x2, 0x3, 0x4 to ch1 → `full[1]`=1, `level[1]`=4. Raise `out_ready` → 0x1 to 0x4 are delivered on consecutive cycles.
4. **Overflow:** ch2 full; write 0x55 with `out_ready[2]`=0 → word dropped, `overflow[2]`=1, `level[2]`=4. Same-cycle `ovf_clr[2]` and a new dropped write → `overflow[2]` stays 1. Clear alone → 0.
5. **Full with simultaneous push and pop:** ch0 full, `out_ready[0]`=1, write 0x99 → no overflow, `level[0]` stays 4, 0x99 emerges fourth.
6. **Broadcast and mid-operation reset:** `wr_en`=3'b101 with 0xA5 → ch0 and ch2 each receive 0xA5, ch1 is unchanged. Assert reset while ch0 holds 3 words → `level` 0, no `out_valid` after release.
